// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester, ALU and response signals of alu_share_ctrl.
// slave  = the controller side, master = the environment (requesters, ALU, consumer).
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 6,
  parameter int unsigned TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_op1;
  logic [WIDTH-1:0] req0_op2;
  logic [SEL_W-1:0] req0_sel;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_op1;
  logic [WIDTH-1:0] req1_op2;
  logic [SEL_W-1:0] req1_sel;
  logic [TAG_W-1:0] req1_tag;

  logic [WIDTH-1:0] alu_operand1;
  logic [WIDTH-1:0] alu_operand2;
  logic [SEL_W-1:0] alu_select;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_sel, req0_tag,
    input  req1_valid, req1_op1, req1_op2, req1_sel, req1_tag,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_operand1, alu_operand2, alu_select,
    output rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_sel, req0_tag,
    output req1_valid, req1_op1, req1_op2, req1_sel, req1_tag,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_operand1, alu_operand2, alu_select,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, operands registered onto the ALU, multiply (select 10)
// held for MUL_LAT cycles, result returned over a valid/ready response.
// Optional macro ALU_SEL_CHECK_EN: selects above 33 return data 0 with rsp_err set.
module alu_share_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_MUL    = SEL_W'(10);
  localparam logic [3:0]       MUL_LOAD   = 4'(MUL_LAT - 1);
  localparam logic             MUL_DIRECT = (MUL_LAT == 1);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [SEL_W-1:0] sel_q;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;
  logic [3:0]       cnt_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic gnt0, gnt1, accept;
  logic is_mul, sel_bad, capture;

  // Round-robin grant: a lone requester wins, on contention the pointer side wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
    end
  end

  assign accept = gnt0 | gnt1;
  assign is_mul = (sel_q == SEL_MUL);

`ifdef ALU_SEL_CHECK_EN
  assign sel_bad = (sel_q > SEL_W'(33));
`else
  assign sel_bad = 1'b0;
`endif

  // Capture point: EXEC for single-cycle ops, last MULW cycle for multiply.
  // The counter is loaded with MUL_LAT-1 and the capture happens in the cycle it
  // would decrement to zero, so EXEC plus the MULW cycles total MUL_LAT hold cycles.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      EXEC:    capture = ~is_mul | MUL_DIRECT;
      MULW:    capture = (cnt_q == 4'd1);
      default: capture = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = capture ? RESP : MULW;
      MULW:    if (capture) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: ready per granted requester, busy outside IDLE.
  always_comb begin
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.busy       = (state_q != IDLE);
  end

  // Datapath: operand latch on accept, multiply counter, result capture and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      sel_q       <= '0;
      tag_q       <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        ptr_q <= gnt0;
        id_q  <= gnt1;
        op1_q <= gnt1 ? bus.req1_op1 : bus.req0_op1;
        op2_q <= gnt1 ? bus.req1_op2 : bus.req0_op2;
        sel_q <= gnt1 ? bus.req1_sel : bus.req0_sel;
        tag_q <= gnt1 ? bus.req1_tag : bus.req0_tag;
      end
      if (state_q == EXEC && !capture) cnt_q <= MUL_LOAD;
      else if (state_q == MULW)        cnt_q <= cnt_q - 4'd1;
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= sel_bad ? '0 : bus.alu_result;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEL_CHECK_EN
  logic err_q;

  // Error flag: set at capture of an illegal select, cleared by the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (capture) err_q <= sel_bad;
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_select   = sel_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_tag      = tag_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed literal checks plus randomized traffic, with a
// transaction-level model checked against the DUT every cycle.
module tb_alu_share_ctrl;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SEL_W   = 6;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .TAG_W(TAG_W)) bus ();

  alu_share_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] s);
    case (s)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd10:   return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU stand-in: the product is only correct once inputs have been stable long enough.
  logic [69:0] prev_in = '0;
  int unsigned hold = 0;
  always @(negedge clk) begin
    if ({bus.alu_operand1, bus.alu_operand2, bus.alu_select} != prev_in) begin
      prev_in <= {bus.alu_operand1, bus.alu_operand2, bus.alu_select};
      hold    <= 0;
    end else if (hold < 15) begin
      hold <= hold + 1;
    end
  end
  assign bus.alu_result = (bus.alu_select == 6'd10 && hold < MUL_LAT - 1) ? 32'hBAD0_BAD0
                        : alu_fn(bus.alu_operand1, bus.alu_operand2, bus.alu_select);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit sel_illegal(input logic [5:0] s);
`ifdef ALU_SEL_CHECK_EN
    return s > 6'd33;
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: one operation in flight, response due a fixed number of cycles after accept.
  bit          m_busy, m_rv, m_ptr, m_id, m_err, m_perr;
  int unsigned m_cnt;
  logic [31:0] m_data, m_op1, m_op2;
  logic [5:0]  m_sel;
  logic [3:0]  m_tag;

  initial begin : compare
    bit e0, e1, v0, v1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_rv = 0; m_ptr = 0; m_id = 0; m_err = 0; m_cnt = 0; m_tag = '0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id_tag", {bus.rsp_id, bus.rsp_tag}, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_alu_ops", bus.alu_operand1 | bus.alu_operand2, 0);
        chk("rst_alu_sel", bus.alu_select, 0);
        continue;
      end
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      e0 = !m_busy && v0 && (!v1 || !m_ptr);
      e1 = !m_busy && v1 && (!v0 ||  m_ptr);
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("busy", bus.busy, m_busy);
      chk("rsp_valid", bus.rsp_valid, m_rv);
      chk("rsp_err", bus.rsp_err, m_err);
      if (m_rv) begin
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_tag", bus.rsp_tag, m_tag);
      end
      if (m_cnt > 0) begin
        chk("alu_op1_hold", bus.alu_operand1, m_op1);
        chk("alu_op2_hold", bus.alu_operand2, m_op2);
        chk("alu_sel_hold", bus.alu_select, m_sel);
      end
      if (e0 || e1) begin
        m_busy = 1;
        m_id   = e1;
        m_ptr  = e0;
        m_op1  = e1 ? bus.req1_op1 : bus.req0_op1;
        m_op2  = e1 ? bus.req1_op2 : bus.req0_op2;
        m_sel  = e1 ? bus.req1_sel : bus.req0_sel;
        m_tag  = e1 ? bus.req1_tag : bus.req0_tag;
        m_perr = sel_illegal(m_sel);
        m_data = m_perr ? 32'd0 : alu_fn(m_op1, m_op2, m_sel);
        m_cnt  = (m_sel == 6'd10) ? MUL_LAT : 1;
        m_err  = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_rv  = 1;
          m_err = m_perr;
        end
      end else if (m_rv && bus.rsp_ready) begin
        m_rv   = 0;
        m_busy = 0;
      end
    end
  end

  // Stimulus helpers; inputs only change 1ns after a rising edge.
  task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] s, input logic [3:0] t);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_sel = s; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_sel = s; bus.req1_tag = t;
    end
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] s, input logic [3:0] t, output int unsigned acc);
    bit ok = 0;
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b, s, t);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin
        ok = 1; acc = cyc; break;
      end
    end
    chk("accept_seen", ok, 1);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, s, t);
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic id, output logic [3:0] t,
                          output logic e, output int unsigned at);
    bit ok = 0;
    d = '0; id = 0; t = '0; e = 0; at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        d = bus.rsp_data; id = bus.rsp_id; t = bus.rsp_tag; e = bus.rsp_err; at = cyc;
        ok = 1; break;
      end
    end
    chk("rsp_seen", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin : stim
    int unsigned acc, at;
    logic [31:0] d;
    logic        id, e;
    logic [3:0]  t;
    bit          seen;
    logic [5:0]  s;

    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Single request: 5 + 3, tag 2.
    issue(0, 5, 3, 0, 2, acc);
    wait_rsp(d, id, t, e, at);
    chk("single_data", d, 8);
    chk("single_id", id, 0);
    chk("single_tag", t, 2);
    chk("single_latency", at - acc, 2);

    // Contention from a fresh pointer: req0 first, then alternating.
    do_reset();
    set_req(0, 1, 10, 4, 1, 1);
    set_req(1, 1, 32'hF0, 32'h3C, 2, 3);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(d, id, t, e, at);
      chk("cont_id", id, (k % 2));
      chk("cont_data", d, (k % 2 == 0) ? 32'd6 : 32'h30);
      chk("cont_tag", t, (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);

    // Multiply 7 * 6.
    issue(0, 7, 6, 10, 5, acc);
    wait_rsp(d, id, t, e, at);
    chk("mul_data", d, 42);
    chk("mul_latency", at - acc, 5);

    // Backpressure with req1 waiting.
    @(posedge clk); #1 bus.rsp_ready = 0;
    issue(0, 1, 2, 0, 7, acc);
    set_req(1, 1, 32'hF0, 32'h3C, 2, 9);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin seen = 1; break; end
    end
    chk("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", bus.rsp_data, 3);
      chk("bp_tag", bus.rsp_tag, 7);
      chk("bp_req1_ready", bus.req1_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1;
    @(negedge clk);
    chk("bp_hs_valid", bus.rsp_valid, 1);
    chk("bp_hs_req1_ready", bus.req1_ready, 0);
    @(negedge clk);
    chk("bp_idle_req1_ready", bus.req1_ready, 1);
    @(posedge clk); #1;
    set_req(1, 0, 0, 0, 0, 0);
    wait_rsp(d, id, t, e, at);
    chk("bp_req1_data", d, 32'h30);
    chk("bp_req1_id", id, 1);
    chk("bp_req1_tag", t, 9);

    // Reset while the multiply counter runs.
    issue(1, 3, 3, 10, 4, acc);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_alu_op1", bus.alu_operand1, 0);
    chk("mrst_alu_sel", bus.alu_select, 0);
    chk("mrst_rsp_valid", bus.rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("mrst_no_rsp", seen, 0);
    @(posedge clk); #1;
    set_req(0, 1, 2, 2, 0, 1);
    set_req(1, 1, 3, 3, 0, 2);
    @(negedge clk);
    chk("mrst_ptr_req0", bus.req0_ready, 1);
    chk("mrst_ptr_req1", bus.req1_ready, 0);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    wait_rsp(d, id, t, e, at);
    chk("mrst_data", d, 4);
    chk("mrst_id", id, 0);

    // Out-of-range select, then a normal op.
    issue(1, 9, 4, 40, 6, acc);
    wait_rsp(d, id, t, e, at);
`ifdef ALU_SEL_CHECK_EN
    chk("badsel_data", d, 0);
    chk("badsel_err", e, 1);
`else
    chk("badsel_data", d, 13);
    chk("badsel_err", e, 0);
`endif
    chk("badsel_latency", at - acc, 2);
    issue(0, 1, 1, 0, 1, acc);
    wait_rsp(d, id, t, e, at);
    chk("after_bad_data", d, 2);
    chk("after_bad_err", e, 0);

    // Randomized traffic, one asynchronous reset pulse in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c == 1500) rst_n = 0;
      if (c == 1502) rst_n = 1;
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 4))
          0: s = 0;
          1: s = 1;
          2: s = 2;
          3: s = 10;
          default: s = 6'($urandom_range(0, 63));
        endcase
        set_req(r[0], 1'($urandom_range(0, 1)), $urandom, $urandom, s, 4'($urandom_range(0, 15)));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
